pipe_fetch_unit: RTL and testbench
==================================

// Module: pipe_fetch_unit
// PURPOSE
//   Parametrised IF stage for the pipelined MIPS core. Merges PC register, PC+step adder and IF/ID
//   register, and adds what the single-cycle-memory fetch path lacks: imem wait states (ready
//   handshake), a FQ_DEPTH-entry prefetch queue, ID stall, and redirect (branch/jump) with flush.
//   Sits between instruction memory / MIO and the ID stage.
// PARAMETERS
//   XLEN      32            datapath / address width
//   RESET_PC  32'h0000_0000 first fetch address after reset
//   FQ_DEPTH  4             prefetch queue entries; power of 2, >= 2
//   PC_STEP   4             byte increment per sequential fetch
// PORTS
//   clk             in   1                      clock, rising edge
//   rst             in   1                      async reset, active-low
//   imem_addr       out  XLEN                   fetch address (fetch_pc)
//   imem_req        out  1                      fetch request valid
//   imem_ready      in   1                      imem_rdata valid for imem_addr this cycle
//   imem_rdata      in   XLEN                   fetched instruction word
//   id_stall        in   1                      ID cannot accept; hold IF/ID
//   redirect_valid  in   1                      taken branch/jump from ID
//   redirect_pc     in   XLEN                   redirect target
//   id_valid        out  1                      IF/ID holds a real instruction
//   id_instruction  out  XLEN                   IF/ID instruction (NOP when !id_valid)
//   id_pc           out  XLEN                   IF/ID instruction address
//   id_pc_4         out  XLEN                   id_pc + PC_STEP
//   fq_count        out  $clog2(FQ_DEPTH+1)     queue occupancy
// BEHAVIOUR
//   Reset (rst=0, async): fetch_pc=RESET_PC, queue empty, state=BOOT, imem_req=0, id_valid=0,
//     id_instruction=NOP(32'h0), id_pc=0, id_pc_4=0, fq_count=0.
//   FSM: BOOT -> FETCH unconditionally (one idle cycle after reset release).
//        FETCH -> HOLD when an accept makes the queue full and no dequeue that cycle.
//        HOLD -> FETCH on any dequeue or redirect. Any state -> FETCH on redirect (except BOOT).
//   imem_req = (state==FETCH); imem_addr = fetch_pc (registered, stable while req && !ready).
//   Accept = imem_req && imem_ready && !redirect_valid: push {fetch_pc, imem_rdata};
//     fetch_pc += PC_STEP, wraps mod 2^XLEN. Response coincident with redirect is discarded.
//   IF/ID advance (id_stall=0, no redirect):
//     queue non-empty -> load head (pop); id_valid=1.
//     queue empty and accept -> bypass imem_rdata directly (not pushed); id_valid=1.
//     else -> bubble: id_valid=0, id_instruction=NOP, id_pc/id_pc_4 hold.
//     Latency: ready-accept at edge N, empty queue -> id_valid at N+1.
//   id_stall=1: IF/ID holds all outputs; queue keeps filling to full; no pop.
//   redirect_valid=1 (priority over stall and accept): queue flushed (count=0), fetch_pc<=redirect_pc,
//     IF/ID <= bubble, state<=FETCH. First target fetch is requested the next cycle.
//   id_pc_4 = id_pc + PC_STEP computed at load, registered, wraps mod 2^XLEN.
//   Queue: strict FIFO order; push+pop same cycle when full is legal (count unchanged);
//     pointers wrap mod FQ_DEPTH; never push when full (guaranteed by imem_req=0 in HOLD).
//   rst asserted mid-transfer: all state to reset values immediately; in-flight response ignored.
// STRUCTURE
//   pipeline_pkg: NOP_INSTR=32'h0000_0000, fetch FSM state enum {BOOT,FETCH,HOLD}, fq entry
//     struct {pc, instr}.
//   Sub-module fetch_queue: parametrised sync FIFO (WIDTH, DEPTH) with push/pop/flush, count,
//     full/empty; flush has priority over push/pop.
//   Top: FSM, fetch_pc register, bypass/advance mux, IF/ID register.
// TESTING
//   1 Reset, imem_ready=1 always, no stall -> imem_addr 0,4,8..; id_valid first high 2 cycles after
//     rst release, id_pc=0, id_pc_4=4, one instruction per cycle, fq_count stays 0.
//   2 imem_ready low 3 cycles at addr 0x8 -> imem_addr held 0x8, id_valid=0 for 3 cycles, no skip.
//   3 id_stall=1 for 6 cycles, ready=1 -> IF/ID frozen, fq_count 1..4, state HOLD, imem_req=0;
//     release -> four queued words exit in order 0x..,+4,+8,+12.
//   4 redirect_valid with redirect_pc=0x100 while queue holds 3 and imem_ready=1 -> fq_count=0,
//     response dropped, id_valid=0 next cycle, next imem_addr=0x100, next id_pc=0x100.
//   5 redirect and id_stall both high -> IF/ID becomes bubble (NOP, id_valid=0), redirect honoured.
//   6 fetch_pc=32'hFFFF_FFFC, accept -> fetch_pc wraps to 0; id_pc_4=0 for that instruction;
//     rst pulsed low mid-wait -> all outputs reset values that cycle.

Source files
------------

// File: rtl/pipe_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package pipe_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/pipe_fetch_unit_fetch_queue.sv
// Synchronous FIFO holding prefetched {pc, instruction} pairs; flush beats push/pop.
module pipe_fetch_unit_fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CW'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count_q alone decides which slots are meaningful.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/pipe_fetch_unit.sv
// IF stage: PC register, imem handshake, prefetch queue and IF/ID register with stall/redirect.
module pipe_fetch_unit
  import pipe_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4,
  parameter int              PC_STEP  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  output logic [XLEN-1:0]               imem_addr_o,
  output logic                          imem_req_o,
  input  logic                          imem_ready_i,
  input  logic [XLEN-1:0]               imem_rdata_i,
  input  logic                          id_stall_i,
  input  logic                          redirect_valid_i,
  input  logic [XLEN-1:0]               redirect_pc_i,
  output logic                          id_valid_o,
  output logic [XLEN-1:0]               id_instruction_o,
  output logic [XLEN-1:0]               id_pc_o,
  output logic [XLEN-1:0]               id_pc_4_o,
  output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count_o
);

  localparam int CW = $clog2(FQ_DEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_instr_q, id_instr_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pc4_q, id_pc4_d;

  logic              accept, advance, pop, push, bypass;
  logic              fq_full, fq_empty;
  logic [2*XLEN-1:0] fq_head;
  logic [CW-1:0]     fq_count;

  assign imem_req_o = (state_q == FETCH);
  assign accept     = imem_req_o && imem_ready_i && !redirect_valid_i;
  assign advance    = !id_stall_i && !redirect_valid_i;
  assign pop        = advance && !fq_empty;
  assign bypass     = advance && fq_empty && accept;
  assign push       = accept && !bypass && (!fq_full || pop);

  pipe_fetch_unit_fetch_queue #(
    .WIDTH(2 * XLEN),
    .DEPTH(FQ_DEPTH)
  ) u_fetch_queue (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(redirect_valid_i),
    .wdata_i({fetch_pc_q, imem_rdata_i}),
    .rdata_o(fq_head),
    .count_o(fq_count),
    .full_o (fq_full),
    .empty_o(fq_empty)
  );

  // HOLD parks the requester once the queue fills, so a push never lands on a full queue.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: if (push && !pop && fq_count == CW'(FQ_DEPTH - 1)) state_d = HOLD;
      HOLD:  if (pop || redirect_valid_i) state_d = FETCH;
      default: state_d = BOOT;
    endcase
    if (redirect_valid_i) begin
      state_d    = FETCH;
      fetch_pc_d = redirect_pc_i;
    end else if (accept) begin
      fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
    end
  end

  always_comb begin
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    if (redirect_valid_i || (advance && !pop && !bypass)) begin
      id_valid_d = 1'b0;
      id_instr_d = XLEN'(NOP_INSTR);
    end else if (pop) begin
      id_valid_d = 1'b1;
      id_pc_d    = fq_head[2*XLEN-1:XLEN];
      id_instr_d = fq_head[XLEN-1:0];
      id_pc4_d   = fq_head[2*XLEN-1:XLEN] + XLEN'(PC_STEP);
    end else if (bypass) begin
      id_valid_d = 1'b1;
      id_pc_d    = fetch_pc_q;
      id_instr_d = imem_rdata_i;
      id_pc4_d   = fetch_pc_q + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= XLEN'(NOP_INSTR);
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
    end
  end

  assign imem_addr_o      = fetch_pc_q;
  assign id_valid_o       = id_valid_q;
  assign id_instruction_o = id_instr_q;
  assign id_pc_o          = id_pc_q;
  assign id_pc_4_o        = id_pc4_q;
  assign fq_count_o       = fq_count;

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Randomised bench for pipe_fetch_unit against a queue-based model of the fetch stage.
module tb_pipe_fetch_unit;

  localparam int FQ_DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] imem_addr_o;
  logic        imem_req_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic        id_stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic [31:0] id_instruction_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc_4_o;
  logic [2:0]  fq_count_o;

  int testCount = 0;
  int failCount = 0;

  logic [63:0] mQ[$];
  logic [31:0] mPc, mInstr, mIdPc, mIdPc4;
  logic        mValid, mBoot;

  pipe_fetch_unit #(
    .XLEN(32), .RESET_PC(32'h0), .FQ_DEPTH(FQ_DEPTH), .PC_STEP(4)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .imem_addr_o     (imem_addr_o),
    .imem_req_o      (imem_req_o),
    .imem_ready_i    (imem_ready_i),
    .imem_rdata_i    (imem_rdata_i),
    .id_stall_i      (id_stall_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .id_valid_o      (id_valid_o),
    .id_instruction_o(id_instruction_o),
    .id_pc_o         (id_pc_o),
    .id_pc_4_o       (id_pc_4_o),
    .fq_count_o      (fq_count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, actual, expected);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mPc = 32'h0; mInstr = 32'h0; mIdPc = 32'h0; mIdPc4 = 32'h0;
    mValid = 1'b0; mBoot = 1'b1;
  endtask

  task automatic checkAll();
    checkOutput("imem_req", 32'(imem_req_o), 32'(!mBoot && mQ.size() < FQ_DEPTH));
    checkOutput("imem_addr", imem_addr_o, mPc);
    checkOutput("id_valid", 32'(id_valid_o), 32'(mValid));
    checkOutput("id_instruction", id_instruction_o, mInstr);
    checkOutput("id_pc", id_pc_o, mIdPc);
    checkOutput("id_pc_4", id_pc_4_o, mIdPc4);
    checkOutput("fq_count", 32'(fq_count_o), 32'(mQ.size()));
  endtask

  task automatic loadId(input logic [63:0] ent);
    mValid = 1'b1;
    mIdPc  = ent[63:32];
    mInstr = ent[31:0];
    mIdPc4 = ent[63:32] + 32'd4;
  endtask

  // The model treats "requesting" as simply "out of boot and room in the queue".
  task automatic stepModel(input logic rdy, input logic stall, input logic redir, input logic [31:0] rpc);
    logic req, acc;
    logic [63:0] ent;
    req = !mBoot && mQ.size() < FQ_DEPTH;
    acc = req && rdy && !redir;
    ent = {mPc, memWord(mPc)};
    if (redir) begin
      mQ.delete();
      mPc = rpc;
      mValid = 1'b0;
      mInstr = 32'h0;
    end else begin
      if (!stall) begin
        if (mQ.size() > 0) begin
          loadId(mQ.pop_front());
          if (acc) mQ.push_back(ent);
        end else if (acc) begin
          loadId(ent);
        end else begin
          mValid = 1'b0;
          mInstr = 32'h0;
        end
      end else if (acc) begin
        mQ.push_back(ent);
      end
      if (acc) mPc = mPc + 32'd4;
    end
    mBoot = 1'b0;
  endtask

  task automatic driveCycle(input logic rdy, input logic stall, input logic redir, input logic [31:0] rpc);
    checkAll();
    imem_ready_i     = rdy;
    id_stall_i       = stall;
    redirect_valid_i = redir;
    redirect_pc_i    = rpc;
    imem_rdata_i     = memWord(mPc);
    stepModel(rdy, stall, redir, rpc);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic applyStimulus(input int n, input int pReady, input int pStall, input int pRedir);
    logic [31:0] rpc;
    for (int i = 0; i < n; i++) begin
      rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
      driveCycle($urandom_range(99) < pReady, $urandom_range(99) < pStall,
                 $urandom_range(99) < pRedir, rpc);
    end
  endtask

  task automatic resetMidCycle();
    checkAll();
    imem_ready_i     = 1'b0;
    id_stall_i       = 1'b0;
    redirect_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1 modelReset();
    checkAll();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni           = 1'b0;
    imem_ready_i     = 1'b0;
    imem_rdata_i     = 32'h0;
    id_stall_i       = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'h0;
    modelReset();
    repeat (2) @(negedge clk_i);
    checkAll();
    rst_ni = 1'b1;

    applyStimulus(20, 100, 0, 0);
    applyStimulus(30, 60, 0, 0);
    applyStimulus(6, 100, 100, 0);
    applyStimulus(8, 100, 0, 0);
    applyStimulus(3, 100, 100, 0);
    driveCycle(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    applyStimulus(5, 100, 0, 0);
    driveCycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    applyStimulus(4, 100, 0, 0);
    driveCycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    applyStimulus(6, 100, 0, 0);
    applyStimulus(200, 70, 30, 5);
    driveCycle(1'b0, 1'b0, 1'b0, 32'h0);
    resetMidCycle();
    applyStimulus(40, 70, 30, 5);
    checkAll();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
